// File: rtl/sar_conv_ctrl.sv
// -----------------------------------------------------------------------------
// sar_conv_ctrl -- conversion sequencer for the time-domain SAR ADC.
//
// Runs one sample phase (samp high for SAMP_CYC cycles) followed by NBITS
// successive-approximation trials. Each trial pulses start for one cycle,
// waits for the comparator decision and updates the DAC trial code. After the
// LSB resolves, dout is published with a one-cycle dout_vld/eoc strobe.
//
// Ports
//   clk, rst_n   clock (rising edge) and asynchronous active-low reset
//   en           block enable; low returns to IDLE on the next edge
//   req          single-shot conversion request, only honoured in IDLE
//   cont         continuous mode; DONE chains straight into SAMPLE
//   cmp_done     comparator decision valid (only observed in WAIT)
//   cmp_out      comparator decision, 1 keeps the trial bit
//   samp         sampling switch control
//   start        comparator start pulse, one cycle per trial
//   dac_code     current trial code to the capacitive DAC
//   dout         last completed conversion result
//   dout_vld     one-cycle strobe, dout updated
//   eoc          end of conversion, coincident with dout_vld
//   busy         high whenever the sequencer is not in IDLE
//   timeout_err  sticky comparator timeout flag
//
// Build option
//   SAR_TIMEOUT_EN  when defined, a WAIT that sees no cmp_done for TO_CYC
//                   cycles resolves the bit as 1 and sets timeout_err.
//                   When undefined, WAIT waits indefinitely and timeout_err
//                   is tied to 0.
// -----------------------------------------------------------------------------
module sar_conv_ctrl #(
  parameter int NBITS    = 8,
  parameter int SAMP_CYC = 2,
  parameter int TO_CYC   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             req,
  input  logic             cont,
  input  logic             cmp_done,
  input  logic             cmp_out,
  output logic             samp,
  output logic             start,
  output logic [NBITS-1:0] dac_code,
  output logic [NBITS-1:0] dout,
  output logic             dout_vld,
  output logic             eoc,
  output logic             busy,
  output logic             timeout_err
);

  localparam int IDX_W = $clog2(NBITS);

  if (NBITS < 2 || NBITS > 16 || SAMP_CYC < 1 || SAMP_CYC > 255 ||
      TO_CYC < 2 || TO_CYC > 255) begin : g_bad_param
    $error("sar_conv_ctrl: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAMPLE,
    S_TRIAL,
    S_WAIT,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       scnt_q, scnt_d;
  logic [NBITS-1:0] dac_q, dac_d;
  logic [NBITS-1:0] dout_q, dout_d;
  logic             samp_q, samp_d;
  logic             start_q, start_d;
  logic             vld_q, vld_d;
  logic             busy_q, busy_d;
  logic             begin_conv;
  logic             resolve;
  logic             bit_val;
`ifdef SAR_TIMEOUT_EN
  logic [7:0]       wcnt_q, wcnt_d;
  logic             terr_q, terr_d;
`endif

  always_comb begin
    // NOTE: every combinational output gets a default before the case so no
    // path leaves a signal unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    idx_d      = idx_q;
    scnt_d     = scnt_q;
    dac_d      = dac_q;
    dout_d     = dout_q;
    samp_d     = 1'b0;
    start_d    = 1'b0;
    vld_d      = 1'b0;
    begin_conv = 1'b0;
    resolve    = 1'b0;
    bit_val    = 1'b0;
`ifdef SAR_TIMEOUT_EN
    wcnt_d     = wcnt_q;
    terr_d     = terr_q;
`endif

    if (!en) begin
      // Abort: pulse outputs fall via their defaults, dout is untouched.
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (req || cont) begin
            begin_conv = 1'b1;
          end
        end
        S_SAMPLE: begin
          if (scnt_q == '0) begin
            state_d            = S_TRIAL;
            start_d            = 1'b1;
            idx_d              = IDX_W'(NBITS - 1);
            dac_d              = '0;
            dac_d[NBITS-1]     = 1'b1;
          end else begin
            samp_d = 1'b1;
            scnt_d = scnt_q - 8'd1;
          end
        end
        S_TRIAL: begin
          // A decision arriving here belongs to no trial and is dropped.
          state_d = S_WAIT;
`ifdef SAR_TIMEOUT_EN
          wcnt_d  = '0;
`endif
        end
        S_WAIT: begin
          resolve = cmp_done;
          bit_val = cmp_out;
`ifdef SAR_TIMEOUT_EN
          if (!cmp_done) begin
            if (wcnt_q == 8'(TO_CYC - 1)) begin
              // No decision: treat as the equal case and keep the bit.
              resolve = 1'b1;
              bit_val = 1'b1;
              terr_d  = 1'b1;
            end else begin
              wcnt_d = wcnt_q + 8'd1;
            end
          end
`endif
          if (resolve) begin
            dac_d[idx_q] = bit_val;
            if (idx_q != '0) begin
              dac_d[idx_q - 1'b1] = 1'b1;
              idx_d               = idx_q - 1'b1;
              state_d             = S_TRIAL;
              start_d             = 1'b1;
            end else begin
              state_d = S_DONE;
            end
          end
        end
        S_DONE: begin
          dout_d = dac_q;
          vld_d  = 1'b1;
          if (cont) begin
            begin_conv = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Shared entry into SAMPLE from IDLE and from DONE in continuous mode.
    if (begin_conv) begin
      state_d = S_SAMPLE;
      samp_d  = 1'b1;
      dac_d   = '0;
      scnt_d  = 8'(SAMP_CYC - 1);
`ifdef SAR_TIMEOUT_EN
      terr_d  = 1'b0;
`endif
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= IDX_W'(NBITS - 1);
      scnt_q  <= '0;
      dac_q   <= '0;
      dout_q  <= '0;
      samp_q  <= 1'b0;
      start_q <= 1'b0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
`ifdef SAR_TIMEOUT_EN
      wcnt_q  <= '0;
      terr_q  <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values; blocking here would create order-dependent races.
      state_q <= state_d;
      idx_q   <= idx_d;
      scnt_q  <= scnt_d;
      dac_q   <= dac_d;
      dout_q  <= dout_d;
      samp_q  <= samp_d;
      start_q <= start_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
`ifdef SAR_TIMEOUT_EN
      wcnt_q  <= wcnt_d;
      terr_q  <= terr_d;
`endif
    end
  end

  assign samp     = samp_q;
  assign start    = start_q;
  assign dac_code = dac_q;
  assign dout     = dout_q;
  assign dout_vld = vld_q;
  assign eoc      = vld_q;
  assign busy     = busy_q;
`ifdef SAR_TIMEOUT_EN
  assign timeout_err = terr_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_sar_conv_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sar_conv_ctrl -- self-checking bench for sar_conv_ctrl (defaults:
// NBITS=8, SAMP_CYC=2, TO_CYC=16). A behavioural comparator answers each
// start pulse after a programmable delay; expected results come from a
// plain binary-search reference and closed-form latency arithmetic.
// -----------------------------------------------------------------------------
module tb_sar_conv_ctrl;

  localparam int NBITS    = 8;
  localparam int SAMP_CYC = 2;
  localparam int TO_CYC   = 16;
  localparam int LAT1     = SAMP_CYC + 2 * NBITS + 1;

  logic             clk = 1'b0;
  logic             rst_n, en, req, cont, cmp_done, cmp_out;
  logic             samp, start, dout_vld, eoc, busy, timeout_err;
  logic [NBITS-1:0] dac_code, dout;

  int n_cmp = 0;
  int n_bad = 0;

  // Monitor counters, updated just after each rising edge.
  int cyc       = 0;
  int start_cnt = 0;
  int samp_cnt  = 0;
  int eoc_cnt   = 0;
  int eoc_cyc   = 0;
  int vld_diff  = 0;

  // Comparator model controls.
  int vin      = 0;
  int dly      = 1;
  bit early    = 1'b0;
  int hang_bit = -1;

  sar_conv_ctrl #(.NBITS(NBITS), .SAMP_CYC(SAMP_CYC), .TO_CYC(TO_CYC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .req        (req),
    .cont       (cont),
    .cmp_done   (cmp_done),
    .cmp_out    (cmp_out),
    .samp       (samp),
    .start      (start),
    .dac_code   (dac_code),
    .dout       (dout),
    .dout_vld   (dout_vld),
    .eoc        (eoc),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Binary search against vin; forced_bit models a timed-out trial.
  function automatic int sar_ref(input int v, input int forced_bit);
    int code = 0;
    for (int b = NBITS - 1; b >= 0; b--) begin
      int t;
      t = code | (1 << b);
      if (b == forced_bit || v >= t) code = t;
    end
    return code;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (rst_n) begin
        if (start) start_cnt++;
        if (samp) samp_cnt++;
        if (eoc) begin
          eoc_cnt++;
          eoc_cyc = cyc;
        end
        if (eoc !== dout_vld) vld_diff++;
      end
    end
  end

  // Comparator: answers dly cycles after seeing start, judging the code that
  // was presented during the start cycle. hang_bit never answers.
  initial begin
    int               rem;
    int               bitn;
    logic [NBITS-1:0] code;
    rem      = 0;
    bitn     = 0;
    code     = '0;
    cmp_done = 1'b0;
    cmp_out  = 1'b0;
    forever begin
      @(negedge clk);
      cmp_done = 1'b0;
      cmp_out  = 1'($urandom_range(0, 1));
      if (start) begin
        code = dac_code;
        bitn = 0;
        for (int b = NBITS - 1; b >= 0; b--) if (code[b]) bitn = b;
        rem = (bitn == hang_bit) ? -1 : dly;
        if (early) begin
          cmp_done = 1'b1;
          cmp_out  = !(vin >= int'(code));
        end
      end else if (rem > 0) begin
        rem--;
        if (rem == 0) begin
          cmp_done = 1'b1;
          cmp_out  = (vin >= int'(code));
        end
      end
    end
  end

  task automatic pulse_req(output int k);
    @(negedge clk);
    req = 1'b1;
    k   = cyc + 1;
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic wait_eoc(input string tag, input int e0, input int limit);
    int n = 0;
    while (eoc_cnt == e0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("%s_eoc_seen", tag), 64'(eoc_cnt - e0), 64'd1);
  endtask

  task automatic wait_starts(input string tag, input int s0, input int n_starts);
    int n = 0;
    while (start_cnt - s0 < n_starts && n < 200) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("%s_reach", tag), 64'(start_cnt - s0), 64'(n_starts));
  endtask

  task automatic run_single(input string tag, input int v, input int d,
                            input bit erl, input bit extra_req);
    int k, e0, s0, p0;
    vin   = v;
    dly   = d;
    early = erl;
    e0    = eoc_cnt;
    s0    = start_cnt;
    p0    = samp_cnt;
    pulse_req(k);
    if (extra_req) begin
      repeat (4) @(negedge clk);
      req = 1'b1;
      @(negedge clk);
      req = 1'b0;
    end
    wait_eoc(tag, e0, 400);
    check($sformatf("%s_lat", tag), 64'(eoc_cyc - k), 64'(SAMP_CYC + NBITS * (1 + d) + 1));
    check($sformatf("%s_dout", tag), 64'(dout), 64'(sar_ref(v, -1)));
    check($sformatf("%s_starts", tag), 64'(start_cnt - s0), 64'(NBITS));
    check($sformatf("%s_samp_cyc", tag), 64'(samp_cnt - p0), 64'(SAMP_CYC));
    @(negedge clk);
    check($sformatf("%s_eoc_1cyc", tag), 64'(eoc), 64'd0);
    check($sformatf("%s_busy_low", tag), 64'(busy), 64'd0);
    if (extra_req) begin
      repeat (30) @(negedge clk);
      check($sformatf("%s_no_requeue", tag), 64'(eoc_cnt - e0), 64'd1);
      check($sformatf("%s_idle_after", tag), 64'(busy), 64'd0);
    end
    early = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int               k, e0, s0, t1, v;
    logic [NBITS-1:0] hold;

    rst_n = 1'b1;
    en    = 1'b1;
    req   = 1'b0;
    cont  = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outs", 64'({samp, start, dac_code, dout, dout_vld, eoc, busy, timeout_err}), 64'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_idle", 64'(busy), 64'd0);

    // Nominal conversion with an ignored request while busy.
    run_single("a5", 'hA5, 1, 1'b0, 1'b1);
    // Slow comparator with early decisions during TRIAL.
    run_single("slow3c", 'h3C, 5, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      run_single($sformatf("rnd%0d", i), int'($urandom_range(1, 255)),
                 int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)), 1'b0);
    end

    // Abort during bit 3: no strobe, dout holds.
    vin  = int'($urandom_range(0, 255));
    dly  = 1;
    hold = dout;
    e0   = eoc_cnt;
    s0   = start_cnt;
    pulse_req(k);
    wait_starts("abort", s0, 5);
    en = 1'b0;
    @(negedge clk);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_pulses", 64'({samp, start, eoc, dout_vld}), 64'd0);
    check("abort_dout_hold", 64'(dout), 64'(hold));
    en = 1'b1;
    repeat (40) @(negedge clk);
    check("abort_no_eoc", 64'(eoc_cnt - e0), 64'd0);
    check("abort_stay_idle", 64'(busy), 64'd0);

    // Continuous mode: 0x00 then 0xFF back to back.
    vin = 0;
    dly = 1;
    e0  = eoc_cnt;
    @(negedge clk);
    cont = 1'b1;
    k    = cyc + 1;
    wait_eoc("cont0", e0, 200);
    check("cont0_lat", 64'(eoc_cyc - k), 64'(LAT1));
    check("cont0_dout", 64'(dout), 64'h00);
    check("cont_samp_restart", 64'(samp), 64'd1);
    check("cont_no_idle", 64'(busy), 64'd1);
    t1   = eoc_cyc;
    vin  = 'hFF;
    cont = 1'b0;
    wait_eoc("cont1", e0 + 1, 200);
    check("cont_period", 64'(eoc_cyc - t1), 64'(LAT1));
    check("cont1_dout", 64'(dout), 64'hFF);

    // Asynchronous reset while waiting on bit 5.
    vin = int'($urandom_range(0, 255));
    dly = 5;
    s0  = start_cnt;
    pulse_req(k);
    wait_starts("rst_b5", s0, 3);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_outs", 64'({samp, start, dac_code, dout, dout_vld, eoc, busy, timeout_err}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("rst_stay_idle", 64'({busy, samp}), 64'd0);

    // Comparator never answers bit 7.
    v        = int'($urandom_range(0, 127));
    vin      = v;
    dly      = 1;
    hang_bit = NBITS - 1;
    e0       = eoc_cnt;
`ifdef SAR_TIMEOUT_EN
    pulse_req(k);
    wait_eoc("to", e0, 200);
    check("to_lat", 64'(eoc_cyc - k), 64'(SAMP_CYC + 2 * (NBITS - 1) + 1 + TO_CYC + 1));
    check("to_dout", 64'(dout), 64'(sar_ref(v, NBITS - 1)));
    check("to_err_set", 64'(timeout_err), 64'd1);
    hang_bit = -1;
    pulse_req(k);
    check("to_err_clear", 64'(timeout_err), 64'd0);
    wait_eoc("to_next", e0 + 1, 200);
    check("to_next_dout", 64'(dout), 64'(sar_ref(v, -1)));
`else
    pulse_req(k);
    repeat (60) @(negedge clk);
    check("hang_no_eoc", 64'(eoc_cnt - e0), 64'd0);
    check("hang_busy", 64'(busy), 64'd1);
    check("hang_no_err", 64'(timeout_err), 64'd0);
    en = 1'b0;
    @(negedge clk);
    check("hang_recover", 64'(busy), 64'd0);
    en       = 1'b1;
    hang_bit = -1;
`endif

    check("vld_eq_eoc", 64'(vld_diff), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
